// File: rtl/reg_access_ctrl.sv
// Register-bank sequencer: read two operands, hand them to the ALU, collect and optionally write back the result.
// Optional BACK_TO_BACK_EN: accept the next descriptor during WRITE and go straight to READ.
module reg_access_ctrl #(
    parameter int size_reg = 16,
    parameter int addr_reg = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [addr_reg-1:0] instr_addr_a,
    input  logic [addr_reg-1:0] instr_addr_b,
    input  logic [addr_reg-1:0] instr_addr_r,
    input  logic                instr_wb,
    output logic [addr_reg-1:0] addr_A,
    output logic [addr_reg-1:0] addr_B,
    output logic [addr_reg-1:0] addr_R,
    output logic                read_reg,
    output logic                write_reg,
    output logic [size_reg-1:0] write_data,
    input  logic [size_reg-1:0] data_A,
    input  logic [size_reg-1:0] data_B,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [size_reg-1:0] op_a,
    output logic [size_reg-1:0] op_b,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [size_reg-1:0] res_data,
    output logic                busy
);

    typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT_RES, WRITE} state_t;

    state_t state;
    logic   wb_q;
    logic   wr_q;
    logic   accept;

    assign accept    = instr_valid & instr_ready;
    // Reset must suppress a bank write even in the cycle it is first asserted.
    assign write_reg = wr_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            read_reg    <= 1'b0;
            wr_q        <= 1'b0;
            op_valid    <= 1'b0;
            res_ready   <= 1'b0;
            wb_q        <= 1'b0;
            addr_A      <= '0;
            addr_B      <= '0;
            addr_R      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            write_data  <= '0;
        end else begin
            case (state)
                READ: begin
                    op_a     <= data_A;
                    op_b     <= data_B;
                    read_reg <= 1'b0;
                    op_valid <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        write_data <= res_data;
                        res_ready  <= 1'b0;
                        if (wb_q) begin
                            wr_q  <= 1'b1;
                            state <= WRITE;
`ifdef BACK_TO_BACK_EN
                            instr_ready <= 1'b1;
`endif
                        end else begin
                            busy        <= 1'b0;
                            instr_ready <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    wr_q        <= 1'b0;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Acceptance overrides the WRITE->IDLE exit when back-to-back is enabled.
            if (accept) begin
                addr_A      <= instr_addr_a;
                addr_B      <= instr_addr_b;
                addr_R      <= instr_addr_r;
                wb_q        <= instr_wb;
                read_reg    <= 1'b1;
                busy        <= 1'b1;
                instr_ready <= 1'b0;
                state       <= READ;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: bank + ALU environment, reference bank model and scoreboarded operations.
module tb_reg_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid, instr_ready, instr_wb;
    logic [1:0]  instr_addr_a, instr_addr_b, instr_addr_r;
    logic [1:0]  addr_A, addr_B, addr_R;
    logic        read_reg, write_reg;
    logic [15:0] write_data, data_A, data_B, op_a, op_b, res_data;
    logic        op_valid, op_ready, res_valid, res_ready, busy;

    reg_access_ctrl #(.size_reg(16), .addr_reg(2)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_addr_a(instr_addr_a), .instr_addr_b(instr_addr_b),
        .instr_addr_r(instr_addr_r), .instr_wb(instr_wb),
        .addr_A(addr_A), .addr_B(addr_B), .addr_R(addr_R),
        .read_reg(read_reg), .write_reg(write_reg), .write_data(write_data),
        .data_A(data_A), .data_B(data_B),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] a, b, r;
        logic       wb;
    } desc_t;

    logic [15:0] bank [4];
    logic [15:0] ref_bank [4];
    desc_t       desc_q [$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          b2b_gap;

    assign data_A = bank[addr_A];
    assign data_B = bank[addr_B];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (write_reg) bank[addr_R] <= write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank();
        for (int i = 0; i < 4; i++) chk($sformatf("bank[%0d]", i), bank[i], ref_bank[i]);
    endtask

    task automatic push(input logic [1:0] a, b, r, input logic wb);
        desc_t d;
        d.a = a; d.b = b; d.r = r; d.wb = wb;
        desc_q.push_back(d);
    endtask

    // Runs every queued descriptor to completion. exp_lat < 0 skips the latency check.
    task automatic run_ops(input int op_lat, input int res_lat, input bit res_const, input int exp_lat);
        desc_t       cur;
        bit          inflight = 0, have_wr = 0;
        int          iw = 0, rw = 0, nrd = 0, nwr = 0, acc_cyc = 0, last_wr = 0, t = 0;
        logic [15:0] ea = 0, eb = 0, er = 0, res_val = 0;
        cur = '0;
        forever begin
            @(negedge clock);
            t++;
            if (t > 300) begin
                vectors++; miscompares++;
                $error("FAIL run_timeout observed=%0d expected<=300", t);
                break;
            end
            if (desc_q.size() == 0 && !inflight && instr_ready && !busy) begin
                if (exp_lat >= 0) chk("latency", cyc - acc_cyc, exp_lat);
                break;
            end
            chk("rd_wr_excl", {31'd0, read_reg & write_reg}, 0);
            if (read_reg) begin
                nrd++;
                chk("addr_A", addr_A, cur.a);
                chk("addr_B", addr_B, cur.b);
                if (have_wr) b2b_gap = cyc - last_wr;
            end
            if (op_valid) begin
                chk("op_a", op_a, ea);
                chk("op_b", op_b, eb);
            end
            if (write_reg) begin
                nwr++;
                chk("addr_R", addr_R, cur.r);
                chk("write_data", write_data, er);
                ref_bank[cur.r] = er;
                last_wr = cyc; have_wr = 1;
                if (inflight) begin
                    chk("reads_per_op", nrd, 1);
                    chk("writes_per_op", nwr, {31'd0, cur.wb});
                    inflight = 0;
                end
            end
            // ALU side: stall counts apply only while the matching handshake is offered.
            if (op_valid) begin
                op_ready = (iw >= op_lat); iw++;
            end else op_ready = 1'($urandom_range(0, 1));
            if (op_valid && op_ready) begin
                iw = 0;
                res_val = res_const ? 16'hFFFF : 16'(op_a + op_b);
            end
            if (res_ready) begin
                res_valid = (rw >= res_lat); res_data = res_val; rw++;
            end else begin
                res_valid = 1'($urandom_range(0, 1)); res_data = 16'($urandom);
            end
            if (res_ready && res_valid) begin
                rw = 0;
                if (inflight && !cur.wb) begin
                    chk("reads_per_op", nrd, 1);
                    chk("writes_per_op", nwr, 0);
                    inflight = 0;
                end
            end
            instr_valid = (desc_q.size() != 0);
            if (instr_valid) begin
                instr_addr_a = desc_q[0].a; instr_addr_b = desc_q[0].b;
                instr_addr_r = desc_q[0].r; instr_wb = desc_q[0].wb;
                if (instr_ready) begin
                    cur = desc_q.pop_front();
                    inflight = 1; acc_cyc = cyc; nrd = 0; nwr = 0;
                    ea = ref_bank[cur.a]; eb = ref_bank[cur.b];
                    er = res_const ? 16'hFFFF : 16'(ea + eb);
                end
            end
        end
        instr_valid = 0; op_ready = 0; res_valid = 0;
    endtask

    initial begin
        bit found;
        reset = 1; instr_valid = 0; instr_wb = 0; op_ready = 0; res_valid = 0; res_data = 0;
        instr_addr_a = 0; instr_addr_b = 0; instr_addr_r = 0;
        for (int i = 0; i < 4; i++) begin bank[i] = 0; ref_bank[i] = 0; end
        bank[1] = 16'h0005; ref_bank[1] = 16'h0005;
        bank[2] = 16'h0003; ref_bank[2] = 16'h0003;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_read_reg", read_reg, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_addrs", {addr_A, addr_B, addr_R}, 0);
        chk("rst_ops", {op_a, op_b}, 0);
        chk("rst_write_data", write_data, 0);
        reset = 0;

        // r3 = r1 + r2, no stalls
        push(1, 2, 3, 1);
        run_ops(0, 0, 0, 5);
        chk("r3_sum", bank[3], 16'h0008);
        check_bank();

        // discarded result
        push(1, 2, 3, 0);
        run_ops(0, 0, 1, 4);
        check_bank();

        // back-pressure on both handshakes
        push(1, 2, 0, 1);
        run_ops(4, 3, 0, 12);
        check_bank();

        // reset while waiting for the result
        @(negedge clock);
        instr_addr_a = 1; instr_addr_b = 2; instr_addr_r = 3; instr_wb = 1;
        instr_valid = 1; op_ready = 1; res_valid = 0;
        @(negedge clock);
        instr_valid = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (res_ready) found = 1; else @(negedge clock);
        end
        chk("reach_wait_res", {31'd0, found}, 1);
        reset = 1;
        @(negedge clock);
        chk("mid_rst_instr_ready", instr_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ctl", {read_reg, write_reg, op_valid, res_ready}, 0);
        chk("mid_rst_addrs", {addr_A, addr_B, addr_R}, 0);
        chk("mid_rst_data", {op_a, op_b}, 0);
        chk("mid_rst_wdata", write_data, 0);
        reset = 0; op_ready = 0;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_no_write", write_reg, 0);
        end
        check_bank();
        push(2, 1, 3, 1);
        run_ops(0, 0, 0, 5);
        check_bank();

        // destination aliases sources
        @(negedge clock);
        bank[2] = 16'h0007; ref_bank[2] = 16'h0007;
        push(2, 2, 2, 1);
        run_ops(0, 0, 0, 5);
        chk("r2_double", bank[2], 16'h000E);

        // back-to-back, second reads first's destination
        b2b_gap = -1;
        push(1, 2, 3, 1);
        push(3, 3, 0, 1);
        run_ops(0, 0, 0, -1);
`ifdef BACK_TO_BACK_EN
        chk("b2b_gap", b2b_gap, 1);
`else
        chk("b2b_gap", b2b_gap, 2);
`endif
        check_bank();

        // randomized descriptor streams
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++)
                push(2'($urandom), 2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            run_ops($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) == 0), -1);
            check_bank();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Sequencing controller that drives the register bank's read/write port on behalf of the datapath. It accepts one operation descriptor (two source addresses, one destination address, a write-back flag), reads both operands from the bank, and hands them to the ALU over a valid/ready handshake. It then collects the ALU result over a second handshake and writes it back to the bank. One operation is in flight at a time; the block sits between the instruction decoder and the register bank/ALU pair.

## Interface
- size_reg, 16, data width of a register (bits)
- addr_reg, 2, register address width; bank holds 2^addr_reg registers

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  descriptor present
- instr_ready  out  1  controller can accept a descriptor
- instr_addr_a  in  addr_reg  source register A
- instr_addr_b  in  addr_reg  source register B
- instr_addr_r  in  addr_reg  destination register
- instr_wb  in  1  1 = write result back, 0 = discard result
- addr_A  out  addr_reg  bank read address A
- addr_B  out  addr_reg  bank read address B
- addr_R  out  addr_reg  bank write address
- read_reg  out  1  bank read enable
- write_reg  out  1  bank write enable
- write_data  out  size_reg  bank write data
- data_A  in  size_reg  bank read data A (combinational from addr_A)
- data_B  in  size_reg  bank read data B (combinational from addr_B)
- op_valid  out  1  operands valid toward ALU
- op_ready  in  1  ALU accepts operands
- op_a  out  size_reg  operand A
- op_b  out  size_reg  operand B
- res_valid  in  1  ALU result present
- res_ready  out  1  controller accepts result
- res_data  in  size_reg  ALU result
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, READ, ISSUE, WAIT_RES, WRITE.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch all three addresses and instr_wb, then go to READ.
- READ (exactly 1 cycle): read_reg=1. addr_A/addr_B driven from the latched addresses. At the end of the cycle, data_A→op_a and data_B→op_b are registered. Go to ISSUE.
- ISSUE: op_valid=1. op_a/op_b are held stable until op_valid & op_ready. On that handshake, go to WAIT_RES.
- WAIT_RES: res_ready=1. On res_valid & res_ready, register res_data→write_data. If the latched wb=1, go to WRITE; otherwise go to IDLE.
- WRITE (exactly 1 cycle): write_reg=1, addr_R = latched destination. Go to IDLE.
- read_reg and write_reg are never high in the same cycle. Both are 0 in IDLE, ISSUE and WAIT_RES.
- Handshakes are honoured only in their own state. res_valid outside WAIT_RES and op_ready outside ISSUE are ignored.
- Address outputs hold their last latched value between operations.
- Destination equal to a source is legal; the read precedes the write, so the old value is used.

## Timing
- Reset values: state=IDLE; instr_ready=1 (combinational from IDLE); all other outputs 0, including addr_*, op_a, op_b and write_data.
- Reset mid-operation: the next edge returns the FSM to IDLE. Pending operands and result are dropped. write_reg is never asserted in a cycle where reset is high.
- Minimum latency, with op_ready and res_valid already high: accept at edge 0, READ cycle 1, ISSUE cycle 2, WAIT_RES cycle 3, WRITE cycle 4, instr_ready again in cycle 5.
- The write takes effect in the bank at the rising edge ending the WRITE cycle.
- Back-pressure: each cycle of op_ready low extends ISSUE by one cycle. Each cycle of res_valid low extends WAIT_RES by one cycle.

## Configuration
- Macro BACK_TO_BACK_EN.
- Defined: instr_ready is also 1 in WRITE. A handshake in WRITE latches the new descriptor and goes directly to READ, saving one cycle per operation. The new READ follows the write edge, so the freshly written value is read.
- Undefined: instr_ready is 1 only in IDLE; WRITE always goes to IDLE.

## Test plan
- Preload bank r1=0x0005, r2=0x0003. Issue (a=1, b=2, r=3, wb=1) with an ALU model returning a+b → op_a=0x0005, op_b=0x0003; write_reg pulses once with addr_R=3, write_data=0x0008; read back r3=0x0008.
- Issue with wb=0, ALU result 0xFFFF → write_reg never asserted; r3 unchanged; FSM returns to IDLE in the cycle after the result handshake.
- Hold op_ready low 4 cycles, then res_valid low 3 cycles → op_a/op_b stable throughout; total accept-to-IDLE is 5+7=12 cycles; no extra read_reg/write_reg pulses.
- Assert reset for one cycle during WAIT_RES → IDLE next cycle, all outputs 0, no write issued; the next descriptor completes normally.
- Issue (a=2, b=2, r=2, wb=1) with r2=0x0007 and ALU output a+b → operands are 0x0007; r2 becomes 0x000E.
- Two back-to-back descriptors, the second reading the first's destination. With BACK_TO_BACK_EN, the second READ is in the cycle after WRITE and sees the new value; without it, there is a one-cycle IDLE gap.
